// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Recovers the hex digits shown on a multiplexed, active-low 7-segment display
// from sampled segment and anode lines. A sample is committed only after
// STABLE consecutive identical qualified samples, which filters out the
// ghosting seen while the display scan switches digits.
//
// Parameters:
//   STABLE       consecutive identical samples needed to commit (1..15)
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   sample_en    seg_n/an_n hold a valid sample this cycle
//   seg_n[7:0]   active-low segments, bit7..bit1 = a..g, bit0 = dp
//   an_n[7:0]    active-low one-hot digit select
//   clear        synchronous clear of value, dp, digit_valid, err and frame tracking
//   value[31:0]  decoded nibbles, value[4i+3:4i] = digit i
//   dp[7:0]      decimal point of each digit at its last commit
//   digit_valid  digit i currently holds a decoded hex pattern
//   err          sticky flag for committed illegal segment or anode patterns
//   frame_done   one-cycle pulse once all eight digits have been committed
module seg7_scan_decoder #(
    parameter int STABLE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_en,
    input  logic [7:0]  seg_n,
    input  logic [7:0]  an_n,
    input  logic        clear,
    output logic [31:0] value,
    output logic [7:0]  dp,
    output logic [7:0]  digit_valid,
    output logic        err,
    output logic        frame_done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] TRACK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [3:0] STABLE_CNT = 4'(STABLE);

    logic [1:0]  state;
    logic [15:0] cand;
    logic [3:0]  cnt;
    logic [7:0]  mask;

    logic [15:0] smp;
    logic        match;
    logic [3:0]  cnt_inc;
    logic        commit;

    logic [7:0]  an_inv;
    logic        an_onehot;
    logic [2:0]  an_idx;
    logic [7:0]  an_bit;

    logic        seg_legal;
    logic        seg_blank;
    logic [3:0]  seg_nib;

    assign smp     = {an_n, seg_n};
    assign match   = (smp == cand);
    assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;

    // Decide whether this edge commits the current sample. With STABLE=1 any
    // fresh candidate commits immediately; otherwise only the match that
    // brings the count up to STABLE does, and LOCKED never re-commits.
    always_comb begin
        commit = 1'b0;
        if (sample_en) begin
            case (state)
                IDLE:    commit = (STABLE_CNT == 4'd1);
                TRACK:   commit = match ? (cnt_inc == STABLE_CNT) : (STABLE_CNT == 4'd1);
                LOCKED:  commit = !match && (STABLE_CNT == 4'd1);
                default: commit = 1'b0;
            endcase
        end
    end

    // Anode check: exactly one low bit selects a digit. The index search
    // only matters when the one-hot test passes.
    assign an_inv    = ~an_n;
    assign an_onehot = (an_inv != 8'h00) && ((an_inv & (an_inv - 8'd1)) == 8'h00);
    assign an_bit    = an_inv;

    always_comb begin
        an_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an_n[i]) an_idx = 3'(i);
        end
    end

    // Segment decode of a..g (active-low) to a hex nibble. All-dark is a
    // blank digit; anything outside the sixteen glyphs is illegal.
    always_comb begin
        seg_legal = 1'b1;
        seg_nib   = 4'h0;
        case (seg_n[7:1])
            7'b0000001: seg_nib = 4'h0;
            7'b1001111: seg_nib = 4'h1;
            7'b0010010: seg_nib = 4'h2;
            7'b0000110: seg_nib = 4'h3;
            7'b1001100: seg_nib = 4'h4;
            7'b0100100: seg_nib = 4'h5;
            7'b0100000: seg_nib = 4'h6;
            7'b0001111: seg_nib = 4'h7;
            7'b0000000: seg_nib = 4'h8;
            7'b0000100: seg_nib = 4'h9;
            7'b0001000: seg_nib = 4'hA;
            7'b1100000: seg_nib = 4'hB;
            7'b0110001: seg_nib = 4'hC;
            7'b1000010: seg_nib = 4'hD;
            7'b0110000: seg_nib = 4'hE;
            7'b0111000: seg_nib = 4'hF;
            default:    seg_legal = 1'b0;
        endcase
    end

    assign seg_blank = (seg_n[7:1] == 7'b1111111);

    // Candidate tracking, commit and frame bookkeeping. Reset beats clear,
    // and clear beats a same-cycle commit. When a commit completes the mask,
    // the mask is dropped to zero on that edge and frame_done pulses for the
    // following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            cand        <= 16'hFFFF;
            value       <= 32'h0;
            dp          <= 8'h00;
            digit_valid <= 8'h00;
            mask        <= 8'h00;
            err         <= 1'b0;
            frame_done  <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            cand        <= 16'hFFFF;
            value       <= 32'h0;
            dp          <= 8'h00;
            digit_valid <= 8'h00;
            mask        <= 8'h00;
            err         <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (sample_en) begin
                if (state == IDLE || !match) begin
                    cand  <= smp;
                    cnt   <= 4'd1;
                    state <= (STABLE_CNT == 4'd1) ? LOCKED : TRACK;
                end else begin
                    cnt <= cnt_inc;
                    if (commit) state <= LOCKED;
                end
            end

            if (commit) begin
                if (!an_onehot) begin
                    err <= 1'b1;
                end else begin
                    value[{an_idx, 2'b00} +: 4] <= seg_legal ? seg_nib : 4'h0;
                    digit_valid[an_idx]         <= seg_legal;
                    dp[an_idx]                  <= ~seg_n[0];
                    if (!seg_legal && !seg_blank) err <= 1'b1;
                    if ((mask | an_bit) == 8'hFF) begin
                        mask       <= 8'h00;
                        frame_done <= 1'b1;
                    end else begin
                        mask <= mask | an_bit;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder (STABLE=3). A behavioural model predicts the
// output snapshot {value, digit_valid, dp, err, frame_done} for every driven
// cycle and pushes it to an expected queue; the DUT snapshot taken after the
// edge goes to an observed queue, and each test drains and compares both.
module tb_seg7_scan_decoder;

    localparam int STABLE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_en = 1'b0;
    logic [7:0]  seg_n = 8'hFF;
    logic [7:0]  an_n = 8'hFF;
    logic        clear = 1'b0;
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  digit_valid;
    logic        err;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    typedef logic [49:0] snap_t;
    snap_t exp_q[$];
    snap_t obs_q[$];

    logic [6:0]  seg_tab [16];

    logic [31:0] m_value;
    logic [7:0]  m_dv;
    logic [7:0]  m_dp;
    logic [7:0]  m_mask;
    logic        m_err;
    logic        m_fd;
    logic [15:0] m_cand;
    int          m_cnt;
    bit          m_has;
    bit          m_locked;

    seg7_scan_decoder #(.STABLE(STABLE)) dut (
        .clk(clk),
        .rst(rst),
        .sample_en(sample_en),
        .seg_n(seg_n),
        .an_n(an_n),
        .clear(clear),
        .value(value),
        .dp(dp),
        .digit_valid(digit_valid),
        .err(err),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Model of what a commit does to the visible outputs and the frame mask.
    task automatic model_commit(input logic [7:0] an, input logic [7:0] seg);
        int idx = 0;
        int ones = 0;
        logic [3:0] nib = 4'h0;
        bit legal = 0;
        bit blank;
        for (int i = 0; i < 8; i++) begin
            if (!an[i]) begin
                ones++;
                idx = i;
            end
        end
        if (ones != 1) begin
            m_err = 1'b1;
            return;
        end
        for (int k = 0; k < 16; k++) begin
            if (seg[7:1] == seg_tab[k]) begin
                legal = 1;
                nib   = 4'(k);
            end
        end
        blank = (seg[7:1] == 7'h7F);
        m_value[idx*4 +: 4] = nib;
        m_dv[idx]   = legal;
        m_dp[idx]   = ~seg[0];
        if (!legal && !blank) m_err = 1'b1;
        m_mask[idx] = 1'b1;
        if (m_mask == 8'hFF) begin
            m_fd   = 1'b1;
            m_mask = 8'h00;
        end
    endtask

    task automatic model_zero();
        m_value = '0; m_dv = '0; m_dp = '0; m_mask = '0; m_err = 0; m_fd = 0;
        m_cand = 16'hFFFF; m_cnt = 0; m_has = 0; m_locked = 0;
    endtask

    // Drive one cycle, predict its outcome, and capture the DUT afterwards.
    task automatic step(input bit en, input logic [7:0] an, input logic [7:0] seg,
                        input bit clr, input bit rs);
        @(negedge clk);
        sample_en = en; an_n = an; seg_n = seg; clear = clr; rst = rs;
        m_fd = 1'b0;
        if (rs || clr) begin
            model_zero();
        end else if (en) begin
            if (m_has && {an, seg} == m_cand) begin
                if (m_cnt < 15) m_cnt++;
                if (!m_locked && m_cnt == STABLE) begin
                    m_locked = 1;
                    model_commit(an, seg);
                end
            end else begin
                m_cand = {an, seg}; m_cnt = 1; m_has = 1; m_locked = 0;
                if (STABLE == 1) begin
                    m_locked = 1;
                    model_commit(an, seg);
                end
            end
        end
        exp_q.push_back({m_value, m_dv, m_dp, m_err, m_fd});
        @(posedge clk);
        #1;
        obs_q.push_back({value, digit_valid, dp, err, frame_done});
    endtask

    task automatic smp(input logic [7:0] an, input logic [7:0] seg);
        step(1'b1, an, seg, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        snap_t e, o;
        step(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1);
        step(1'b1, 8'hFE, 8'h00, 1'b1, 1'b1);
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL reset: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_single_commit();
        snap_t e, o;
        smp(8'hFE, {seg_tab[3], 1'b1});
        smp(8'hFE, {seg_tab[3], 1'b1});
        smp(8'hFE, {seg_tab[5], 1'b1});
        repeat (3) smp(8'hFE, {seg_tab[3], 1'b1});
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL single_commit: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_interrupt();
        snap_t e, o;
        smp(8'hFD, {seg_tab[2], 1'b0});
        smp(8'hFD, {seg_tab[2], 1'b0});
        smp(8'hFD, {seg_tab[6], 1'b0});
        smp(8'hFD, {seg_tab[2], 1'b0});
        idle();
        smp(8'hFD, {seg_tab[2], 1'b0});
        idle();
        idle();
        smp(8'hFD, {seg_tab[2], 1'b0});
        repeat (18) smp(8'hFD, {seg_tab[2], 1'b0});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL interrupt: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_frame();
        snap_t e, o;
        step(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        for (int d = 0; d < 8; d++) begin
            repeat (3) smp(~(8'h01 << d), {seg_tab[d+1], 1'b1});
        end
        idle();
        idle();
        for (int d = 0; d < 7; d++) begin
            repeat (3) smp(~(8'h01 << d), {seg_tab[15-d], 1'b0});
        end
        repeat (3) smp(8'hFE, {seg_tab[9], 1'b1});
        repeat (3) smp(8'h7F, {seg_tab[12], 1'b0});
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL frame: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_illegal_an();
        snap_t e, o;
        repeat (3) smp(8'hFC, {seg_tab[4], 1'b1});
        idle();
        repeat (3) smp(8'h00, {seg_tab[4], 1'b1});
        step(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL illegal_an: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_blank();
        snap_t e, o;
        repeat (3) smp(8'hDF, {seg_tab[7], 1'b1});
        repeat (3) smp(8'hDF, 8'b1111111_0);
        idle();
        repeat (3) smp(8'hDF, 8'b1010101_1);
        idle();
        repeat (3) smp(8'hDF, {seg_tab[8], 1'b1});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL blank: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        snap_t e, o;
        repeat (3) smp(8'hEF, {seg_tab[1], 1'b1});
        smp(8'hFB, {seg_tab[7], 1'b1});
        smp(8'hFB, {seg_tab[7], 1'b1});
        step(1'b1, 8'hFB, {seg_tab[7], 1'b1}, 1'b0, 1'b1);
        smp(8'hFB, {seg_tab[7], 1'b1});
        idle();
        smp(8'hFB, {seg_tab[7], 1'b1});
        smp(8'hFB, {seg_tab[7], 1'b1});
        smp(8'hF7, {seg_tab[9], 1'b0});
        smp(8'hF7, {seg_tab[9], 1'b0});
        step(1'b1, 8'hF7, {seg_tab[9], 1'b0}, 1'b1, 1'b0);
        smp(8'hF7, {seg_tab[9], 1'b0});
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL reset_mid: got %h expected %h", o, e);
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        model_zero();
        test_reset();
        test_single_commit();
        test_interrupt();
        test_frame();
        test_illegal_an();
        test_blank();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE, default 3, meaning consecutive identical samples required before a digit is committed (legal range 1-15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 sample_en  input  1  qualifies seg_n/an_n as a sample this cycle; ignored when low.
REQ-005 seg_n  input  8  captured segment lines, active-low; bit7..bit1 = a..g, bit0 = dp.
REQ-006 an_n  input  8  captured digit select, active-low one-hot; bit i low = digit i.
REQ-007 clear  input  1  synchronous clear of captured value, masks and err.
REQ-008 value  output  32  decoded hex nibbles; value[4i+3:4i] = digit i.
REQ-009 dp  output  8  dp[i] = 1 when digit i decimal point lit at last commit.
REQ-010 digit_valid  output  8  digit_valid[i] = 1 when digit i holds a decoded hex pattern (not blank).
REQ-011 err  output  1  sticky: an illegal segment pattern or illegal an_n was committed.
REQ-012 frame_done  output  1  one-cycle pulse when all 8 digit positions committed since last pulse/clear.

Function
REQ-013 States: IDLE (no candidate), TRACK (candidate held, counting), LOCKED (candidate committed, waiting for change).
REQ-014 IDLE, sample_en=1: latch {an_n, seg_n} as candidate, cnt=1; if STABLE=1 commit same cycle and go LOCKED, else go TRACK.
REQ-015 TRACK, sample_en=1, sample equals candidate: cnt increments; when cnt reaches STABLE, commit on that edge and go LOCKED.
REQ-016 TRACK or LOCKED, sample_en=1, sample differs: new sample becomes candidate, cnt=1, go TRACK (IDLE rule for STABLE=1).
REQ-017 sample_en=0: state, candidate and cnt hold; non-sampled cycles never break stability.
REQ-018 LOCKED, matching sample: no further commit; cnt saturates, never wraps.
REQ-019 Commit with an_n not exactly one zero bit: value/dp/digit_valid/commit mask unchanged, err set.
REQ-020 Commit decode of seg_n[7:1] (active-low a..g): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-021 Legal pattern commit: nibble i <= decoded value, digit_valid[i]=1, dp[i]=~seg_n[0], mask[i]=1.
REQ-022 Blank commit (seg_n[7:1]=1111111): nibble i <= 0, digit_valid[i]=0, dp[i]=~seg_n[0], mask[i]=1.
REQ-023 Any other pattern commit: nibble i <= 0, digit_valid[i]=0, dp[i]=~seg_n[0], mask[i]=1, err set.
REQ-024 When a commit makes mask=8'hFF: frame_done=1 on the following cycle for exactly one cycle; mask returns to 0 in that same edge.
REQ-025 Re-committing an already-masked digit updates its value but does not change mask.
REQ-026 clear=1: value, dp, digit_valid, mask, err <= 0, frame_done <= 0, state IDLE; clear overrides a same-cycle commit.
REQ-027 err, once set, holds until clear or rst.
REQ-028 Outputs registered; value/dp/digit_valid reflect a commit one cycle after the committing edge's sample.

Reset
REQ-029 rst=1: state IDLE, cnt=0, candidate=16'hFFFF, value=0, dp=0, digit_valid=0, mask=0, err=0, frame_done=0.
REQ-030 rst has priority over clear and sample_en; reset mid-TRACK discards the candidate with no commit.

Verification
REQ-031 STABLE=3, an_n=8'hFE, seg_n=8'b0000110_1 for 3 sample_en cycles -> value[3:0]=3, digit_valid[0]=1, dp[0]=0, err=0; 2 cycles only -> no change.
REQ-032 Stable digit 2 pattern interrupted by one different sample at cnt=2 -> no commit until 3 fresh matches; sample_en low gaps between matches still commit.
REQ-033 Scan digits 0..7 with 1,2,...,8 each held 3 samples -> value=32'h87654321, digit_valid=8'hFF, single frame_done pulse, mask 0 after.
REQ-034 an_n=8'hFC stable 3 samples -> err=1, value unchanged; then clear=1 -> err=0, value=0.
REQ-035 seg_n=8'b1111111_0 on digit 5 -> digit_valid[5]=0, dp[5]=1, nibble 5=0, err=0; seg_n=8'b1010101_1 -> err=1.
REQ-036 rst asserted at cnt=2 of a candidate, released, one matching sample -> no commit (cnt restarts at 1).
